// File: rtl/multicycle_control.sv
// Control FSM for a multicycle MIPS-subset datapath: sequences fetch, decode,
// memory, ALU and write-back steps and drives the datapath enables and selects.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic       ExtSel,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11
  } state_t;

  state_t state;
  logic   imm_ori;  // ORI vs ADDI, captured in DECODE so IEXEC/IWB agree
  logic   op_known;

  // The branch condition (PCWriteCond & Zero) is formed in the datapath.
  logic   unused_zero;
  assign unused_zero = Zero;

  assign op_known = (Opcode == OP_R)   || (Opcode == OP_LW)   || (Opcode == OP_SW) ||
                    (Opcode == OP_BEQ) || (Opcode == OP_J)    ||
                    (Opcode == OP_ADDI) || (Opcode == OP_ORI);

  // NOTE: sequential state uses non-blocking assignments only; mixing in
  // blocking writes here would make simulation order-dependent.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      imm_ori <= 1'b0;
    end else begin
      case (state)
        FETCH:  if (MemReady) state <= DECODE;
        DECODE: begin
          imm_ori <= (Opcode == OP_ORI);
          case (Opcode)
            OP_LW, OP_SW:     state <= MEMADR;
            OP_R:             state <= EXEC;
            OP_BEQ:           state <= BRANCH;
            OP_J:             state <= JUMP;
            OP_ADDI, OP_ORI:  state <= IEXEC;
            default:          state <= FETCH;
          endcase
        end
        MEMADR: state <= (Opcode == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  if (MemReady) state <= MEMWB;
        MEMWR:  if (MemReady) state <= FETCH;
        EXEC:   state <= RWB;
        IEXEC:  state <= IWB;
        default: state <= FETCH;  // MEMWB, RWB, BRANCH, JUMP, IWB, and 12-15
      endcase
    end
  end

  assign State = state;

  // NOTE: every output gets a default before the case so no latches are inferred.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    ExtSel      = 1'b0;
    IllegalOp   = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE: begin
        ALUSrcB   = 2'b11;
        ExtSel    = 1'b1;
        IllegalOp = !op_known;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtSel  = 1'b1;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtSel  = !imm_ori;
        ALUOp   = imm_ori ? 2'b11 : 2'b00;
      end
      IWB: begin
        RegWrite = 1'b1;
        ExtSel   = !imm_ori;
        ALUOp    = imm_ori ? 2'b11 : 2'b00;
      end
      default: IllegalOp = 1'b1;
    endcase

    // Nothing may write or touch memory while reset is held.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      MemRead     = 1'b0;
      IllegalOp   = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have no parameters; opcode and state encodings are fixed by this document.
REQ-002 Ports, clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- Opcode  in  6  instruction bits [31:26], valid from DECODE onward.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory handshake; the access completes in the cycle where MemReady=1.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  out  1 each  datapath controls.
- PCSource, ALUOp, ALUSrcB  out  2 each  datapath mux and ALU selects.
- ExtSel  out  1  immediate extension: 1 = sign-extend Imm16, 0 = zero-extend.
- IllegalOp  out  1  one-cycle pulse on an unsupported opcode.
- State  out  4  current state, for debug.

Function
REQ-003 SHALL implement a 12-state FSM; State encodings 0-11 are: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, IEXEC, IWB.
REQ-004 Supported opcodes SHALL be: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000, ORI=001101.
REQ-005 Outputs SHALL decode from State only, except the MemReady-qualified enables in REQ-006, REQ-010 and REQ-011; all outputs not named in a state are 0.
REQ-006 FETCH outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite SHALL be 1 only when MemReady=1.
REQ-007 FETCH transitions: it SHALL hold while MemReady=0 and go to DECODE when MemReady=1.
REQ-008 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00 and ExtSel=1. It SHALL then branch on Opcode:
- LW or SW -> MEMADR
- R -> EXEC
- BEQ -> BRANCH
- J -> JUMP
- ADDI or ORI -> IEXEC
- any other opcode -> FETCH, with IllegalOp=1 in the DECODE cycle.
REQ-009 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00 and ExtSel=1. It goes to MEMRD if Opcode=LW, else to MEMWR.
REQ-010 MEMRD SHALL drive MemRead=1 and IorD=1. It holds until MemReady=1, then goes to MEMWB.
REQ-011 MEMWR SHALL drive IorD=1 and MemWrite=1. It holds until MemReady=1, then goes to FETCH. MemWrite SHALL remain 1 for every cycle spent in MEMWR.
REQ-012 MEMWB SHALL drive RegDst=0, MemtoReg=1 and RegWrite=1, then go to FETCH.
REQ-013 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RWB.
REQ-014 RWB SHALL drive RegDst=1, MemtoReg=0 and RegWrite=1, then go to FETCH.
REQ-015 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1 and PCSource=01, then go to FETCH. The effective PC load is PCWriteCond AND Zero, formed in the datapath.
REQ-016 JUMP SHALL drive PCWrite=1 and PCSource=10, then go to FETCH.
REQ-017 IEXEC SHALL drive ALUSrcA=1, ALUSrcB=10, then go to IWB.
- ADDI: ExtSel=1, ALUOp=00.
- ORI: ExtSel=0, ALUOp=11.
REQ-018 IWB SHALL drive RegDst=0, MemtoReg=0 and RegWrite=1. It holds ExtSel and ALUOp at their IEXEC values, then goes to FETCH.
REQ-019 Instruction latency in cycles, with zero memory wait:
- J and BEQ: 3
- R, ADDI, ORI and SW: 4
- LW: 5
Each memory wait cycle adds 1.
REQ-020 Unused encodings 12-15 SHALL go to FETCH on the next edge with IllegalOp=1 for that one cycle.

Reset
REQ-021 When reset=1 at a rising edge, State SHALL become FETCH regardless of the current state, including mid-wait in MEMRD or MEMWR.
REQ-022 While reset=1, all write enables SHALL be forced to 0: PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite. MemRead and IllegalOp SHALL also be 0.
REQ-023 In the first cycle after reset deasserts, outputs SHALL equal the FETCH decode of REQ-006.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Reset, then LW with MemReady=1 on every memory cycle -> State sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4.
- SW with MemReady held 0 for 3 cycles in MEMWR -> State stays 5 for 4 cycles with MemWrite=1 throughout, then goes to 0.
- ORI -> ExtSel=0 and ALUOp=11 in states 10 and 11. ADDI -> ExtSel=1 and ALUOp=00 in the same states.
- BEQ with Zero=1 and then with Zero=0 -> State sequence 0,1,8,0 in both cases, with PCWriteCond=1 and PCSource=01 in state 8.
- Opcode=111111 -> IllegalOp=1 for exactly one cycle in DECODE, next State=0, and no RegWrite or MemWrite.
- reset asserted while waiting in MEMRD -> next State=0 and MemRead=0 while reset is high.
